// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/SS/MOSI in the clk domain, decodes all four
// SPI modes, returns MISO from a one-entry tx buffer and pulses rx_valid per byte.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sclk_d, r_ss_d;
  logic                   r_cpol, r_cpha, r_skip, r_reload;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_rx_shift, r_tx_shift, r_tx_buf, r_rx_data;
  logic                   r_tx_full, r_rx_valid, r_miso;

  logic w_sclk, w_ss, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic w_lead, w_trail, w_start, w_stop, w_sample, w_shift, w_consume;
  logic w_miso_next;
  logic [DATA_W-1:0] w_rx_next;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = r_ss_d & ~w_ss;
  assign w_ss_rise   = ~r_ss_d & w_ss;

  // Leading edge moves SCLK away from its idle level, trailing edge returns it.
  assign w_lead    = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail   = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_start   = (r_state == IDLE) & w_ss_fall;
  assign w_stop    = (r_state == ACTIVE) & w_ss_rise;
  assign w_sample  = (r_state == ACTIVE) & ~w_ss_rise & (r_cpha ? w_trail : w_lead);
  assign w_shift   = (r_state == ACTIVE) & ~w_ss_rise & (r_cpha ? w_lead : w_trail);
  assign w_consume = w_start | (w_shift & ~r_skip & r_reload);
  assign w_rx_next = {r_rx_shift[DATA_W-2:0], w_mosi};

  // NOTE: sequential state uses <= only so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_state_next = ACTIVE;
      ACTIVE:  if (w_ss_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_miso_next = 1'b0;
    if (r_state == ACTIVE && w_state_next == ACTIVE) w_miso_next = r_tx_shift[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_skip     <= 1'b0;
      r_reload   <= 1'b0;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_miso     <= w_miso_next;
      if (w_start) begin
        r_cpol     <= mode[1];
        r_cpha     <= mode[0];
        r_skip     <= mode[0];
        r_reload   <= 1'b0;
        r_bit_cnt  <= '0;
        r_tx_shift <= r_tx_full ? r_tx_buf : '0;
      end else if (w_stop) begin
        r_skip    <= 1'b0;
        r_reload  <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        if (w_sample) begin
          r_rx_shift <= w_rx_next;
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            r_bit_cnt  <= '0;
            r_reload   <= 1'b1;
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        if (w_shift) begin
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (r_reload) begin
            r_tx_shift <= r_tx_full ? r_tx_buf : '0;
            r_reload   <= 1'b0;
          end else begin
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  // A consume in the same cycle as a load wins; the load is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_full <= 1'b0;
      r_tx_buf  <= '0;
    end else if (w_consume) begin
      r_tx_full <= 1'b0;
    end else if (tx_load && !r_tx_full) begin
      r_tx_buf  <= tx_data;
      r_tx_full <= 1'b1;
    end
  end

  assign tx_ready = ~r_tx_full;
  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = ~w_ss;

endmodule
